// File: rtl/vexec_pkg.sv
// vexec_pkg: opcodes, lane geometry and reduction FSM states for vector_exec_unit
package vexec_pkg;
  localparam int LANES = 8;
  localparam int LANE_W = 32;
  localparam logic [2:0] OP_VADD = 3'd0;
  localparam logic [2:0] OP_VSUB = 3'd1;
  localparam logic [2:0] OP_VMUL = 3'd2;
  localparam logic [2:0] OP_VRELU = 3'd3;
  localparam logic [2:0] OP_VMAX = 3'd4;
  localparam logic [2:0] OP_VREDSUM = 3'd5;
  typedef enum logic {IDLE, REDUCE} state_t;
endpackage

// File: rtl/vexec_lane.sv
// vexec_lane: combinational single-lane ALU; unknown opcodes yield 0
module vexec_lane #(
  parameter int LANE_W = vexec_pkg::LANE_W
) (
  input  logic [2:0]        op_code,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] y
);
  import vexec_pkg::*;
  always_comb
    y = op_code == OP_VADD ? a + b :
        op_code == OP_VSUB ? a - b :
        op_code == OP_VMUL ? a * b :
        op_code == OP_VRELU ? (!a[LANE_W-1] && |a ? a : '0) :
        op_code == OP_VMAX ? ($signed(a) > $signed(b) ? a : b) : '0;
endmodule

// File: rtl/vector_exec_unit.sv
// vector_exec_unit: two-stage elementwise vector ALU; VEXEC_REDSUM_EN adds a sequential
// sum-reduction that back-pressures issue while it walks the lanes.
module vector_exec_unit #(
  parameter int LANES = vexec_pkg::LANES,
  parameter int LANE_W = vexec_pkg::LANE_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [2:0]              op_code,
  input  logic [4:0]              vd_sel,
  input  logic [2:0]              vlmul,
  input  logic [LANES*LANE_W-1:0] op0_in,
  input  logic [LANES*LANE_W-1:0] op1_in,
  output logic [4:0]              wb_sel,
  output logic [LANES*LANE_W-1:0] wb_in,
  output logic                    wb_load,
  output logic                    busy
);
  import vexec_pkg::*;
  localparam int W = LANES * LANE_W;
  localparam int IW = $clog2(LANES);
  logic accept, start_red, s1_valid, wr_ew, red_done;
  logic [2:0] s1_op;
  logic [4:0] s1_vd;
  logic [IW:0] s1_n;
  logic [W-1:0] s1_a, s1_b, y, res;
  logic [LANE_W-1:0] red_sum;
  assign accept = issue_valid && issue_ready;
  assign wr_ew = s1_valid && s1_op <= OP_VMAX;
  // the stage-1 operands double as the reduction source, since issue stalls in REDUCE
  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else begin
      s1_valid <= accept && !start_red;
      if (accept) begin
        s1_op <= op_code;
        s1_vd <= vd_sel;
        s1_n <= vlmul[2] ? (IW+1)'(1) : (IW+1)'(1) << vlmul[1:0];
        s1_a <= op0_in;
        s1_b <= op1_in;
      end
    end
  end
  for (genvar g = 0; g < LANES; g++) begin : gl
    vexec_lane #(.LANE_W(LANE_W)) u_lane (
      .op_code(s1_op),
      .a(s1_a[g*LANE_W +: LANE_W]),
      .b(s1_b[g*LANE_W +: LANE_W]),
      .y(y[g*LANE_W +: LANE_W])
    );
    assign res[g*LANE_W +: LANE_W] = (IW+1)'(g) < s1_n ? y[g*LANE_W +: LANE_W] : '0;
  end
`ifdef VEXEC_REDSUM_EN
  state_t state, state_n;
  logic [IW-1:0] k;
  logic [LANE_W-1:0] acc;
  assign issue_ready = state == IDLE;
  assign start_red = accept && op_code == OP_VREDSUM;
  assign red_sum = acc + s1_a[{k, {$clog2(LANE_W){1'b0}}} +: LANE_W];
  assign busy = s1_valid || wb_load || state == REDUCE;
  always_comb begin
    state_n = state;
    red_done = 1'b0;
    if (state == IDLE && start_red) state_n = REDUCE;
    if (state == REDUCE && {1'b0, k} == s1_n - 1'b1) begin
      state_n = IDLE;
      red_done = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
    if (start_red) begin
      acc <= op1_in[LANE_W-1:0];
      k <= '0;
    end else if (state == REDUCE) begin
      acc <= red_sum;
      k <= k + 1'b1;
    end
  end
`else
  assign issue_ready = 1'b1;
  assign start_red = 1'b0;
  assign red_done = 1'b0;
  assign red_sum = '0;
  assign busy = s1_valid || wb_load;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_load <= 1'b0;
      wb_sel <= '0;
      wb_in <= '0;
    end else begin
      wb_load <= wr_ew || red_done;
      if (wr_ew || red_done) begin
        wb_sel <= s1_vd;
        wb_in <= red_done ? W'(red_sum) : res;
      end
    end
  end
endmodule

// File: tb/tb_vector_exec_unit.sv
// tb_vector_exec_unit: directed table of elementwise vectors plus hand-written reduction/reset sequences
module tb_vector_exec_unit;
  import vexec_pkg::*;
  typedef struct {
    logic [2:0]   op;
    logic [2:0]   vl;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] y;
    logic         ld;
  } vec_t;
  logic clk = 0, reset = 1, issue_valid = 0, issue_ready, wb_load, busy;
  logic [2:0] op_code = 0, vlmul = 0;
  logic [4:0] vd_sel = 0, wb_sel;
  logic [255:0] op0_in = 0, op1_in = 0, wb_in;
  int checks = 0, errors = 0;
  logic [260:0] seen [$];
  vec_t tv [8];
  always #5 clk = ~clk;
  always @(negedge clk) if (wb_load) seen.push_back({wb_sel, wb_in});
  vector_exec_unit dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op_code(op_code), .vd_sel(vd_sel), .vlmul(vlmul), .op0_in(op0_in), .op1_in(op1_in),
    .wb_sel(wb_sel), .wb_in(wb_in), .wb_load(wb_load), .busy(busy)
  );
  function automatic logic [255:0] l8(input logic [31:0] v0, v1, v2, v3, v4, v5, v6, v7);
    return {v7, v6, v5, v4, v3, v2, v1, v0};
  endfunction
  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [4:0] vd, input logic [2:0] vl, input logic [255:0] a, input logic [255:0] b);
    op_code = op;
    vd_sel = vd;
    vlmul = vl;
    op0_in = a;
    op1_in = b;
    issue_valid = 1;
    @(posedge clk);
    #1 issue_valid = 0;
  endtask
  initial begin
    tv[0] = '{OP_VADD, 3'd3, l8(1, 2, 3, 4, 5, 6, 7, 8), l8(10, 10, 10, 10, 10, 10, 10, 10), l8(11, 12, 13, 14, 15, 16, 17, 18), 1'b1};
    tv[1] = '{OP_VMUL, 3'd1, l8(32'h8000_0000, 3, 5, 5, 5, 5, 5, 5), l8(2, 32'hFFFF_FFFF, 5, 5, 5, 5, 5, 5), l8(0, 32'hFFFF_FFFD, 0, 0, 0, 0, 0, 0), 1'b1};
    tv[2] = '{OP_VRELU, 3'd2, l8(32'hFFFF_FFFB, 7, 0, 32'h8000_0000, 9, 9, 9, 9), l8(1, 2, 3, 4, 5, 6, 7, 8), l8(0, 7, 0, 0, 0, 0, 0, 0), 1'b1};
    tv[3] = '{3'd7, 3'd3, l8(1, 2, 3, 4, 5, 6, 7, 8), l8(1, 2, 3, 4, 5, 6, 7, 8), '0, 1'b0};
    tv[4] = '{OP_VSUB, 3'd2, l8(0, 100, 200, 300, 400, 500, 600, 700), l8(1, 1, 1, 1, 1, 1, 1, 1), l8(32'hFFFF_FFFF, 99, 199, 299, 0, 0, 0, 0), 1'b1};
    tv[5] = '{OP_VMAX, 3'd1, l8(32'hFFFF_FFFF, 5, 9, 9, 9, 9, 9, 9), l8(3, 2, 9, 9, 9, 9, 9, 9), l8(3, 5, 0, 0, 0, 0, 0, 0), 1'b1};
    tv[6] = '{OP_VMAX, 3'd5, l8(32'h8000_0000, 9, 9, 9, 9, 9, 9, 9), l8(32'hFFFF_FFFF, 9, 9, 9, 9, 9, 9, 9), l8(32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0), 1'b1};
    tv[7] = '{OP_VADD, 3'd0, l8(32'hFFFF_FFFF, 4, 4, 4, 4, 4, 4, 4), l8(2, 4, 4, 4, 4, 4, 4, 4), l8(1, 0, 0, 0, 0, 0, 0, 0), 1'b1};
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_load", wb_load, 0);
    chk("rst_sel", wb_sel, 0);
    chk("rst_in", wb_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", issue_ready, 1);
    for (int i = 0; i < 8; i++) begin
      issue(tv[i].op, 5'(i + 1), tv[i].vl, tv[i].a, tv[i].b);
      @(negedge clk);
      chk($sformatf("t%0d_c1_load", i), wb_load, 0);
      chk($sformatf("t%0d_c1_busy", i), busy, 1);
      chk($sformatf("t%0d_c1_ready", i), issue_ready, 1);
      @(negedge clk);
      chk($sformatf("t%0d_c2_load", i), wb_load, tv[i].ld);
      if (tv[i].ld) begin
        chk($sformatf("t%0d_sel", i), wb_sel, 5'(i + 1));
        chk($sformatf("t%0d_in", i), wb_in, tv[i].y);
      end
      @(negedge clk);
      chk($sformatf("t%0d_c3_idle", i), {busy, wb_load}, 0);
    end
    seen.delete();
    for (int j = 0; j < 3; j++) issue(OP_VADD, 5'(10 + j), 3'd0, l8(j, 1, 1, 1, 1, 1, 1, 1), l8(100, 1, 1, 1, 1, 1, 1, 1));
    repeat (4) @(negedge clk);
    chk("b2b_count", seen.size(), 3);
    for (int j = 0; j < seen.size(); j++) begin
      chk($sformatf("b2b%0d_sel", j), seen[j][260:256], 5'(10 + j));
      chk($sformatf("b2b%0d_in", j), seen[j][255:0], l8(100 + j, 0, 0, 0, 0, 0, 0, 0));
    end
`ifdef VEXEC_REDSUM_EN
    issue(OP_VREDSUM, 5'd20, 3'd2, l8(1, 2, 3, 4, 50, 50, 50, 50), l8(100, 7, 7, 7, 7, 7, 7, 7));
    op_code = OP_VADD;
    vd_sel = 5'd21;
    vlmul = 3'd0;
    issue_valid = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("red_c%0d_ready", c), issue_ready, 0);
      chk($sformatf("red_c%0d_load", c), wb_load, 0);
      chk($sformatf("red_c%0d_busy", c), busy, 1);
    end
    @(negedge clk);
    issue_valid = 0;
    chk("red_load", wb_load, 1);
    chk("red_sel", wb_sel, 20);
    chk("red_in", wb_in, l8(110, 0, 0, 0, 0, 0, 0, 0));
    chk("red_ready_back", issue_ready, 1);
    @(negedge clk);
    chk("red_c6_load", wb_load, 0);
    @(negedge clk);
    chk("red_c7_idle", {busy, wb_load}, 0);
    issue(OP_VADD, 5'd3, 3'd0, l8(7, 1, 1, 1, 1, 1, 1, 1), l8(8, 1, 1, 1, 1, 1, 1, 1));
    issue(OP_VREDSUM, 5'd4, 3'd0, l8(20, 1, 1, 1, 1, 1, 1, 1), l8(22, 1, 1, 1, 1, 1, 1, 1));
    @(negedge clk);
    chk("mix_c2_load", wb_load, 1);
    chk("mix_c2_sel", wb_sel, 3);
    chk("mix_c2_in", wb_in, l8(15, 0, 0, 0, 0, 0, 0, 0));
    chk("mix_c2_ready", issue_ready, 0);
    @(negedge clk);
    chk("mix_c3_load", wb_load, 1);
    chk("mix_c3_sel", wb_sel, 4);
    chk("mix_c3_in", wb_in, l8(42, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("mix_c4_load", wb_load, 0);
    issue(OP_VREDSUM, 5'd9, 3'd3, l8(1, 2, 3, 4, 5, 6, 7, 8), l8(1, 0, 0, 0, 0, 0, 0, 0));
`else
    issue(OP_VREDSUM, 5'd7, 3'd3, l8(1, 2, 3, 4, 5, 6, 7, 8), l8(1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    chk("op5_c1_ready", issue_ready, 1);
    @(negedge clk);
    chk("op5_c2_load", wb_load, 0);
    @(negedge clk);
    chk("op5_c3_busy", busy, 0);
    issue(OP_VADD, 5'd9, 3'd3, l8(1, 2, 3, 4, 5, 6, 7, 8), l8(1, 0, 0, 0, 0, 0, 0, 0));
`endif
    @(posedge clk);
    #1 reset = 1;
    @(posedge clk);
    #1 reset = 0;
    seen.delete();
    @(negedge clk);
    chk("rst2_busy", busy, 0);
    chk("rst2_ready", issue_ready, 1);
    chk("rst2_load", wb_load, 0);
    repeat (12) @(negedge clk);
    chk("rst2_no_wb", seen.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vector_exec_unit.md
# vector_exec_unit

Vector execute stage sitting directly downstream of the vector register file's operand read ports and upstream of its writeback port. Takes the two 256-bit operand groups (op0, op1), performs an element-wise 32-bit lane operation or a sequential sum-reduction, and drives the register file's `wb_sel` / `wb_in` / `wb_load` with a registered result. Elementwise ops are fully pipelined at one per cycle. The reduction is multi-cycle and back-pressures issue.

## Interface

Parameters:
- LANES, 8, number of 32-bit lanes in an operand group (256 / 32)
- LANE_W, 32, lane width in bits

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  operation presented this cycle
- issue_ready  out  1  unit can accept an operation this cycle
- op_code  in  3  operation select
- vd_sel  in  5  destination register base index
- vlmul  in  3  register grouping for this op
- op0_in  in  256  operand group 0 from the register file
- op1_in  in  256  operand group 1 from the register file
- wb_sel  out  5  destination index to the register file
- wb_in  out  256  result data to the register file
- wb_load  out  1  one-cycle write strobe
- busy  out  1  any operation accepted but not yet written back

## Operation

- Accept when `issue_valid && issue_ready`. `op_code`, `vd_sel`, `vlmul`, `op0_in` and `op1_in` are sampled only on accept.
- Active lanes: L = 1 << vlmul for vlmul 0..3 (1/2/4/8 lanes). vlmul 4..7 is reserved and treated as 0 (L = 1).
- Lane i occupies bits [32i+31:32i]. Inactive lanes of `wb_in` are driven 0.
- Opcodes:
  - 000 VADD: a+b
  - 001 VSUB: a−b
  - 010 VMUL: low 32 bits of a*b
  - 011 VRELU: a if signed a > 0, else 0 (b ignored)
  - 100 VMAX: signed max(a, b)
  - 101 VREDSUM: see below
  - 110, 111: reserved; accepted and completed with `wb_load` held 0
- Arithmetic is modulo 2^32; there is no saturation and no flags.
- VREDSUM: lane 0 of the result = op1 lane 0 + Σ op0 active lanes (mod 2^32). All other lanes are 0.
- FSM states:
  - IDLE: `issue_ready` = 1. Accepting VREDSUM moves to REDUCE with acc ← op1 lane 0 and lane counter k ← 0.
  - REDUCE: each cycle acc ← acc + op0 lane k, k ← k+1. After the cycle with k = L−1, acc is loaded into the output register and the FSM returns to IDLE.
  - `issue_ready` = 0 in REDUCE.
- Results leave in issue order; at most one `wb_load` per cycle, with no collisions by construction.
- `busy` = 1 when stage-1 is valid, the FSM is in REDUCE, or `wb_load` is pending.

## Timing

- Accept at cycle N (elementwise): stage-1 operand register at N+1, output register at N+2. `wb_load` = 1 for exactly cycle N+2, with `wb_sel` / `wb_in` valid in the same cycle.
- Accept VREDSUM at N: REDUCE occupies cycles N+1..N+L, `wb_load` = 1 at N+L+1, `issue_ready` = 0 during N+1..N+L. For L = 1 the latency equals the elementwise latency (2).
- An elementwise op accepted at N−1 writes at N+1 and never collides with a reduction accepted at N.
- Back-to-back elementwise accepts give one `wb_load` per cycle.
- Reset (synchronous) state: `wb_load`=0, `wb_sel`=0, `wb_in`=0, `busy`=0, `issue_ready`=1, FSM in IDLE, stage-1 valid cleared.
- Reset mid-REDUCE or with ops in flight discards them; no `wb_load` is issued for discarded ops.
- `issue_ready` is a function of state only, not of `issue_valid`, so no combinational loop exists.

## Configuration

- Macro: `VEXEC_REDSUM_EN`.
- Defined: VREDSUM and the REDUCE state are built as described above.
- Undefined:
  - op 101 is reserved (accepted, no `wb_load`)
  - the FSM and accumulator are removed
  - `issue_ready` is constant 1

## Structure

- Package `vexec_pkg` holds the opcode localparams (OP_VADD … OP_VREDSUM), LANES, LANE_W, and the FSM state typedef (IDLE, REDUCE).
- Sub-module `vexec_lane` is the combinational single-lane ALU (op_code, a, b → y), instantiated LANES times.
- The top level owns:
  - the stage-1 register
  - the reduction FSM and accumulator
  - lane masking
  - the output register

## Test plan

- VADD, vlmul=3, op0 lanes = 1..8, op1 lanes = 10 each, accept at cycle 0 → `wb_load` at cycle 2 only, `wb_in` lanes = 11..18, `wb_sel` = `vd_sel`.
- VMUL, vlmul=1, op0 lanes = 0x8000_0000 and 3, op1 lanes = 2 and 0xFFFF_FFFF → lanes 0x0000_0000 and 0xFFFF_FFFD, lanes 2..7 = 0.
- VREDSUM, vlmul=2, op0 lanes = 1, 2, 3, 4, op1 lane 0 = 100:
  - accept at 0 → `issue_ready` = 0 during cycles 1..4
  - `wb_load` at 5 with lane 0 = 110, other lanes 0
- VADD accepted at cycle 0, then VREDSUM (vlmul=0) accepted at cycle 1 → `wb_load` at cycles 2 and 3, in order.
- Reset asserted at cycle 2 of a vlmul=3 VREDSUM → no `wb_load` afterward, `busy` = 0 and `issue_ready` = 1 in the cycle after reset.
- Opcode 111 and VRELU on −5 / 7 → opcode 111 gives no `wb_load`; VRELU gives lanes 0 / 7.
